// File: rtl/ram_4x4_sync.sv
// ram_4x4_sync: 4-word x 4-bit single-port RAM with a registered read port.
// One rdwr line selects read (1) or write (0); en gates the access; RST
// (synchronous, active-high) clears every word and the read register.
// Optional feature macro: RAM_WRITE_THROUGH_EN -- when defined, a write also
// loads data_out with the written value on the same edge.
module ram_4x4_sync #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] ad_in,
    input  logic              en,
    input  logic              rdwr,
    output logic [DATA_W-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] data_out_q;
    logic [DATA_W-1:0] data_out_d;
    logic              wr_en;
    logic              rd_en;

    assign wr_en = en & ~rdwr;
    assign rd_en = en &  rdwr;

    // Next-state of the storage array and the read register for an un-reset edge
    always_comb begin
        mem_d      = mem_q;
        data_out_d = data_out_q;
        if (wr_en) begin
            mem_d[ad_in] = data_in;
`ifdef RAM_WRITE_THROUGH_EN
            data_out_d = data_in;
`endif
        end else if (rd_en) begin
            data_out_d = mem_q[ad_in];
        end
    end

    // Stage p0 -> registered state: reset has priority and discards the access
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            data_out_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_ram_4x4_sync.sv
// Self-checking bench for ram_4x4_sync: directed plan scenarios plus a
// randomized run checked against an array-based reference model.
module tb_ram_4x4_sync;

    logic       CLK;
    logic       RST;
    logic [3:0] data_in;
    logic [1:0] ad_in;
    logic       en;
    logic       rdwr;
    logic [3:0] data_out;

    int n_checks;
    int n_pass;

    // Reference model: the memory contents and the read register as the
    // specification describes them
    logic [3:0] mdl_mem [4];
    logic [3:0] mdl_out;

    ram_4x4_sync #(.DATA_W(4), .ADDR_W(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .data_in  (data_in),
        .ad_in    (ad_in),
        .en       (en),
        .rdwr     (rdwr),
        .data_out (data_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one cycle at the falling edge, let the rising edge take it,
    // then advance the model and leave the bench 1 time unit past the edge.
    task automatic cycle(input logic r, input logic e, input logic rw,
                         input logic [1:0] a, input logic [3:0] d);
        @(negedge CLK);
        RST = r; en = e; rdwr = rw; ad_in = a; data_in = d;
        @(posedge CLK);
        #1;
        if (r) begin
            for (int i = 0; i < 4; i++) mdl_mem[i] = 4'b0000;
            mdl_out = 4'b0000;
        end else if (e) begin
            if (rw) begin
                mdl_out = mdl_mem[a];
            end else begin
                mdl_mem[a] = d;
`ifdef RAM_WRITE_THROUGH_EN
                mdl_out = d;
`endif
            end
        end
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b0, 2'b00, 4'b1111);
        n_checks++;
        if (data_out !== 4'b0000)
            $display("FAIL reset_out: got %b expected %b", data_out, 4'b0000);
        else n_pass++;
        for (int a = 0; a < 4; a++) begin
            cycle(1'b0, 1'b1, 1'b1, 2'(a), 4'($urandom));
            n_checks++;
            if (data_out !== 4'b0000)
                $display("FAIL reset_read_%0d: got %b expected %b", a, data_out, 4'b0000);
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        logic [3:0] exp_after_wr;
`ifdef RAM_WRITE_THROUGH_EN
        exp_after_wr = 4'b1011;
`else
        exp_after_wr = 4'b0000;
`endif
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 4'b1011);
        n_checks++;
        if (data_out !== exp_after_wr)
            $display("FAIL write_edge_out: got %b expected %b", data_out, exp_after_wr);
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b1, 2'b10, 4'b0110);
        n_checks++;
        if (data_out !== 4'b1011)
            $display("FAIL read_after_write: got %b expected %b", data_out, 4'b1011);
        else n_pass++;
    endtask

    task automatic test_disable();
        cycle(1'b0, 1'b0, 1'b0, 2'b11, 4'b0101);
        n_checks++;
        if (data_out !== 4'b1011)
            $display("FAIL disable_hold: got %b expected %b", data_out, 4'b1011);
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b1, 2'b11, 4'b1111);
        n_checks++;
        if (data_out !== 4'b0000)
            $display("FAIL disable_no_write: got %b expected %b", data_out, 4'b0000);
        else n_pass++;
    endtask

    task automatic test_read_hold();
        cycle(1'b0, 1'b1, 1'b1, 2'b10, 4'b0000);
        n_checks++;
        if (data_out !== 4'b1011)
            $display("FAIL hold_read: got %b expected %b", data_out, 4'b1011);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'($urandom), 2'($urandom), 4'($urandom));
            n_checks++;
            if (data_out !== 4'b1011)
                $display("FAIL hold_cycle_%0d: got %b expected %b", k, data_out, 4'b1011);
            else n_pass++;
        end
    endtask

    task automatic test_fill();
        logic [3:0] vals [4];
        vals[0] = 4'b0011; vals[1] = 4'b1001; vals[2] = 4'b1011; vals[3] = 4'b1000;
        for (int a = 0; a < 4; a++) cycle(1'b0, 1'b1, 1'b0, 2'(a), vals[a]);
        for (int a = 3; a >= 0; a--) begin
            cycle(1'b0, 1'b1, 1'b1, 2'(a), 4'($urandom));
            n_checks++;
            if (data_out !== vals[a])
                $display("FAIL fill_read_%0d: got %b expected %b", a, data_out, vals[a]);
            else n_pass++;
        end
    endtask

    task automatic test_midrun_reset();
        cycle(1'b1, 1'b1, 1'b1, 2'b01, 4'b0000);
        n_checks++;
        if (data_out !== 4'b0000)
            $display("FAIL midrun_reset_out: got %b expected %b", data_out, 4'b0000);
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b1, 2'b01, 4'b0000);
        n_checks++;
        if (data_out !== 4'b0000)
            $display("FAIL midrun_reset_read: got %b expected %b", data_out, 4'b0000);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            cycle(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom), 2'($urandom), 4'($urandom));
            n_checks++;
            if (data_out !== mdl_out)
                $display("FAIL random_%0d: got %b expected %b", k, data_out, mdl_out);
            else n_pass++;
        end
        // Sweep every address so the whole array is compared at least once
        for (int a = 0; a < 4; a++) begin
            cycle(1'b0, 1'b1, 1'b1, 2'(a), 4'($urandom));
            n_checks++;
            if (data_out !== mdl_mem[a])
                $display("FAIL random_sweep_%0d: got %b expected %b", a, data_out, mdl_mem[a]);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        RST = 1'b0; en = 1'b0; rdwr = 1'b0; ad_in = 2'b00; data_in = 4'b0000;
        for (int i = 0; i < 4; i++) mdl_mem[i] = 4'b0000;
        mdl_out = 4'b0000;
        test_reset();
        test_write_read();
        test_disable();
        test_read_hold();
        test_fill();
        test_midrun_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
